// File: rtl/qos_pkg.sv
// Shared constants and types for the four-queue QoS scheduler.
// WRR weights are only consumed when QOS_WRR_EN is defined.
package qos_pkg;

  localparam int NUM_Q         = 4;
  localparam int DEPTH_DEFAULT = 6;
  localparam int CNT_W         = 3;

  localparam logic [2:0] WEIGHT0 = 3'd4;
  localparam logic [2:0] WEIGHT1 = 3'd3;
  localparam logic [2:0] WEIGHT2 = 3'd2;
  localparam logic [2:0] WEIGHT3 = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_POP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] qbuf;
    logic [1:0] data;
  } pkt_t;

  function automatic logic [2:0] weight(input logic [1:0] q);
    case (q)
      2'd0:    return WEIGHT0;
      2'd1:    return WEIGHT1;
      2'd2:    return WEIGHT2;
      default: return WEIGHT3;
    endcase
  endfunction

endpackage

// File: rtl/qos_fifo.sv
// Circular FIFO of 2-bit entries; a push to a full queue is taken only
// when a pop of the same queue happens in that cycle.
module qos_fifo
  import qos_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [1:0]       data_i,
  output logic [1:0]       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop_s, do_push_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign count_o   = cnt_q;
  assign data_o    = mem_q[rd_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
      rd_q  <= {PW{1'b0}};
      wr_q  <= {PW{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop_s) rd_q <= ptr_inc(rd_q);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/qos_scheduler.sv
// Four-queue packet scheduler: strict priority by default, weighted
// round robin (4,3,2,1) when QOS_WRR_EN is defined.
module qos_scheduler
  import qos_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DROP_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_valid,
  input  logic [1:0]        enq_buf,
  input  logic [1:0]        enq_data,
  input  logic              deq_tick,
  output logic              deq_valid,
  output logic [1:0]        deq_buf,
  output logic [1:0]        deq_data,
  output logic [11:0]       occ,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  state_e            state_q;
  logic [1:0]        gnt_q, gnt_s;
  logic              gnt_ok_s;
  logic              deq_valid_q, busy_q;
  pkt_t              deq_pkt_q;
  logic [DROP_W-1:0] drop_q;
  logic [NUM_Q-1:0]  push_s, pop_s, full_s, empty_s;
  logic [1:0]        head_s [NUM_Q];
  logic [CNT_W-1:0]  cnt_s  [NUM_Q];
  logic              drop_s;

  for (genvar q = 0; q < NUM_Q; q++) begin : g_q
    assign push_s[q] = enq_valid && (enq_buf == 2'(q));
    assign pop_s[q]  = (state_q == S_POP) && (gnt_q == 2'(q));
    assign occ[3*q +: 3] = cnt_s[q];

    qos_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s[q]),
      .pop_i   (pop_s[q]),
      .data_i  (enq_data),
      .data_o  (head_s[q]),
      .full_o  (full_s[q]),
      .empty_o (empty_s[q]),
      .count_o (cnt_s[q])
    );
  end

  // A pop of the target queue in the same cycle frees the slot for the push.
  assign drop_s = enq_valid && full_s[enq_buf] && !pop_s[enq_buf];

`ifdef QOS_WRR_EN
  logic [1:0] ptr_q, ptr_d, cand_s;
  logic [2:0] credit_q, credit_d;
  logic       found_s;

  // Stay on the current queue while it has credit, else move to the next non-empty one.
  always_comb begin
    gnt_s    = 2'd0;
    gnt_ok_s = 1'b0;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    found_s  = 1'b0;
    cand_s   = 2'd0;
    if (!empty_s[ptr_q] && (credit_q != 3'd0)) begin
      gnt_s    = ptr_q;
      gnt_ok_s = 1'b1;
      credit_d = credit_q - 3'd1;
    end else begin
      for (int k = 1; k <= NUM_Q; k++) begin
        cand_s = ptr_q + 2'(k);
        if (!found_s && !empty_s[cand_s]) begin
          found_s = 1'b1;
          gnt_s   = cand_s;
        end else begin
          found_s = found_s;
        end
      end
      gnt_ok_s = found_s;
      ptr_d    = gnt_s;
      credit_d = weight(gnt_s) - 3'd1;
    end
  end

  // Pointer and credit advance only on an actual grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= 2'd0;
      credit_q <= WEIGHT0;
    end else if ((state_q == S_ARB) && gnt_ok_s) begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end
`else
  // Lowest-numbered non-empty queue wins.
  always_comb begin
    gnt_s    = 2'd0;
    gnt_ok_s = 1'b1;
    casez (empty_s)
      4'b???0: gnt_s = 2'd0;
      4'b??01: gnt_s = 2'd1;
      4'b?011: gnt_s = 2'd2;
      4'b0111: gnt_s = 2'd3;
      default: begin
        gnt_s    = 2'd0;
        gnt_ok_s = 1'b0;
      end
    endcase
  end
`endif

  // Scheduler FSM with registered departure strobe, busy and drop counter.
  // busy also covers the cycle in which the departure strobe is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'd0;
      deq_valid_q <= 1'b0;
      deq_pkt_q   <= '0;
      busy_q      <= 1'b0;
      drop_q      <= {DROP_W{1'b0}};
    end else begin
      deq_valid_q <= 1'b0;
      busy_q      <= (state_q != S_IDLE) || deq_tick;
      case (state_q)
        S_IDLE: begin
          if (deq_tick) state_q <= S_ARB;
        end
        S_ARB: begin
          if (gnt_ok_s) begin
            state_q <= S_POP;
            gnt_q   <= gnt_s;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_POP: begin
          state_q        <= S_IDLE;
          deq_valid_q    <= 1'b1;
          deq_pkt_q.qbuf <= gnt_q;
          deq_pkt_q.data <= head_s[gnt_q];
        end
        default: state_q <= S_IDLE;
      endcase
      if (drop_s && (drop_q != {DROP_W{1'b1}})) drop_q <= drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end

  assign deq_valid = deq_valid_q;
  assign deq_buf   = deq_pkt_q.qbuf;
  assign deq_data  = deq_pkt_q.data;
  assign drop_cnt  = drop_q;
  assign busy      = busy_q;

endmodule

// File: doc/qos_scheduler.md
QOS_SCHEDULER -- requirements
Module: qos_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 6, giving slots per queue.
REQ-002 SHALL have parameter DROP_W, default 11, giving the width of the drop counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enq_valid, input, 1 bit: packet-present strobe, one cycle per packet.
REQ-006 SHALL have port enq_buf, input, 2 bits: target queue 0-3.
REQ-007 SHALL have port enq_data, input, 2 bits: packet payload.
REQ-008 SHALL have port deq_tick, input, 1 bit: departure-slot pulse.
REQ-009 SHALL have port deq_valid, output, 1 bit: one-cycle departure strobe.
REQ-010 SHALL have port deq_buf, output, 2 bits: queue served.
REQ-011 SHALL have port deq_data, output, 2 bits: departed payload.
REQ-012 SHALL have port occ, output, 12 bits: per-queue occupancy, 3 bits per queue, queue0 in bits [2:0].
REQ-013 SHALL have port drop_cnt, output, DROP_W bits: total tail drops.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 SHALL keep four independent FIFOs of DEPTH 2-bit entries.
REQ-016 SHALL store enq_data at the queue tail when enq_valid=1 and the target queue is not full.
REQ-017 SHALL discard the packet when the target queue holds DEPTH entries and no pop of that queue occurs in the same cycle, incrementing drop_cnt and saturating at all-ones.
REQ-018 SHALL accept the enqueue when a pop and a push hit the same full queue in one cycle; the pop takes effect first and occupancy is unchanged.
REQ-019 SHALL implement FSM states IDLE, ARB and POP with these transitions: IDLE goes to ARB on deq_tick; ARB goes to POP when a grant exists, otherwise back to IDLE; POP always goes to IDLE.
REQ-020 SHALL ignore deq_tick while in ARB or POP (no queuing of ticks).
REQ-021 SHALL, in POP, assert deq_valid for exactly one cycle with deq_buf and deq_data taken from the granted queue head, and remove that head.
REQ-022 SHALL therefore present deq_valid 2 cycles after the deq_tick edge; if all queues are empty, no deq_valid is produced.
REQ-023 SHALL, under strict priority, grant the lowest-numbered non-empty queue.
REQ-024 SHALL update occ in the cycle following each push or pop; occ never exceeds DEPTH.
REQ-025 SHALL hold deq_buf and deq_data at their last values when deq_valid=0.

Reset
REQ-026 SHALL, on rst_n low, immediately empty all queues and force occ=0, drop_cnt=0, deq_valid=0, deq_buf=0, deq_data=0, busy=0, FSM=IDLE and reset the WRR pointer and credits.
REQ-027 SHALL, on reset during POP, abort the pop with no deq_valid and no data loss accounting.

Configuration
REQ-028 SHALL, when QOS_WRR_EN is defined, replace strict priority with weighted round robin using weights 4,3,2,1 for queues 0-3.
REQ-029 SHALL, in that WRR mode, keep the pointer on the current queue while it is non-empty and has credit, decrementing credit per grant.
REQ-030 SHALL, in that WRR mode, advance the pointer cyclically to the next non-empty queue and reload its credit when credit reaches 0 or the queue is empty.
REQ-031 SHALL use strict priority (REQ-023) and omit pointer and credit logic when QOS_WRR_EN is undefined.

Structure
REQ-032 SHALL place NUM_Q=4, DEPTH default, the WEIGHT constants, the FSM state typedef and the packet typedef {buf[1:0], data[1:0]} in shared package qos_pkg.
REQ-033 SHALL instantiate sub-module qos_fifo (push, pop, data, full, empty, count) four times.

Verification
REQ-034 SHALL verify: 6 enqueues to queue 2, then a 7th -> occ[8:6]=6 and drop_cnt=1.
REQ-035 SHALL verify: queue1 holds {1,2,3} and a deq_tick is given -> 2 cycles later deq_valid=1, deq_buf=1, deq_data=1 and occ[5:3]=2.
REQ-036 SHALL verify: all queues empty, deq_tick -> no deq_valid, and busy high for 2 cycles.
REQ-037 SHALL verify: queue0 full, enq to queue0 coinciding with its POP cycle -> no drop and occ[2:0] stays 6.
REQ-038 SHALL verify, with QOS_WRR_EN defined: all queues filled to 6, 10 ticks -> served order 0,0,0,0,1,1,1,2,2,3; without QOS_WRR_EN -> 6 from queue 0, then 4 from queue 1.
REQ-039 SHALL verify: rst_n pulsed low mid-POP -> deq_valid=0 and all outputs return to zero asynchronously.
